instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch front end for the RV32 core: owns the program counter and issues word fetch requests to `Instruction_mem`, the read responder. Returned words are buffered in a small in-order prefetch FIFO and presented to decode with a valid/ready handshake. Branch/jump redirects flush buffered words and discard fetches already in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, prefetch FIFO entries, power of two, ≥2
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch byte address, word aligned
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  branch/jump taken, one-cycle pulse
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored
- `if_valid`  out  1  instruction available to decode
- `if_instr`  out  32  instruction word
- `if_pc`  out  32  address of `if_instr`
- `if_ready`  in  1  decode accepts instruction

## Operation
- Registered `pc`: reset `RESET_PC`; +4 on each accepted request (`imem_req && imem_ready`); loaded with `{redirect_pc[31:2],2'b00}` on redirect (redirect wins).
- `imem_addr = pc`. `imem_req = (credit > 0) && !redirect_valid`, where `credit = DEPTH - fifo_count - outstanding`, computed from registered values only.
- `outstanding`: +1 per accepted request, −1 per `imem_rvalid`; never exceeds `DEPTH`.
- Responses arrive in order, ≥1 cycle after acceptance. Each accepted request pushes `{pc_at_issue, rdata}` unless discarded; FIFO stores issue PC alongside the word.
- `discard` counter: on redirect, loaded with the in-flight count after this cycle's updates (`outstanding` − this cycle's rvalid; no request accepted in a redirect cycle). While `discard > 0`, each rvalid decrements `discard` and is dropped.
- Redirect: FIFO flushed same edge; a simultaneous pop and rvalid are both ignored (pop is harmless, rvalid counted as discarded).
- Pop on `if_valid && if_ready`. Push and pop in the same cycle on a full FIFO is legal only because credit prevents overflow; FIFO never overflows by construction.
- If `imem_ready` is low, `imem_req` and `imem_addr` hold until accepted or until a redirect.

## Timing
- Reset (async, `rst` low): `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, counters and FIFO empty, immediately, without a clock edge.
- First cycle after `rst` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency: accept at cycle N, 1-cycle memory rvalid at N+1, `if_valid` at N+2 (FIFO is registered, no bypass).
- Throughput: 1 instr/cycle sustained with `DEPTH`≥4, 1-cycle memory, and `if_ready` high.
- Redirect at cycle R: `if_valid`=0 at R+1; `imem_addr`=new PC and `imem_req`=1 at R+1; first new instruction visible at R+3 with a 1-cycle memory.
- Back-to-back redirects: the latest one wins; `discard` reloads each time.

## Structure
- Package `rv_fetch_pkg`: `XLEN`=32, `PC_STEP`=4, `INSTR_NOP`=32'h0000_0013, typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, depth `DEPTH`, with push, pop, flush, count, and async active-low reset. Its head drives the `if_*` outputs directly.

## Test plan
- Release reset with `RESET_PC`=0, a 1-cycle memory returning `rdata`=addr, and `if_ready`=1: `imem_addr` is 0,4,8,… on consecutive cycles; first `if_valid` arrives 2 cycles after the first accept with `if_pc`=0 and `if_instr`=0, then one instruction per cycle.
- Hold `if_ready`=0 for 10 cycles: `imem_req` drops once `fifo_count`+`outstanding`=4; on release, `if_pc` is 0,4,8,12,16 in order with no loss.
- Redirect to 32'h43 with 2 requests outstanding: both responses are dropped; `if_valid`=0 the next cycle; `imem_addr`=32'h40; the next delivered `if_pc`=32'h40.
- Redirect in the same cycle as `imem_rvalid` and a pop: that response is dropped, `discard` counts only the remaining in-flight fetches, and no stale `if_pc` ever appears.
- Hold `imem_ready`=0 for 3 cycles while `imem_req`=1: `imem_addr` stays at 32'h8 and `pc` does not advance; the fetch resumes at 32'h8.
- Assert `rst` low mid-stream, between clock edges: `imem_req`, `if_valid`, `if_instr`, and `if_pc` go to 0 and `imem_addr` to `RESET_PC` without a clock edge; after release, fetch restarts at `RESET_PC` and late rvalids from the memory (reset externally) are not present.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer holding fetched words with their issue PC.
// Head is presented combinationally; outputs read as zero while empty.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            wpc_i,
  input  logic [XLEN-1:0]            winstr_i,
  output logic                       valid_o,
  output logic [XLEN-1:0]            rpc_o,
  output logic [XLEN-1:0]            rinstr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; occupancy is tracked by the reset counters above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{pc: wpc_i, instr: winstr_i};
  end

  assign head     = mem_q[rd_ptr_q];
  assign valid_o  = (count_q != '0);
  assign rpc_o    = valid_o ? head.pc : '0;
  assign rinstr_o = valid_o ? head.instr : '0;
  assign count_o  = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch front end: PC generation, credit-limited request issue,
// in-order response tracking with redirect discard, and prefetch buffering.
module instr_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic            run_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     level;
  logic [XLEN-1:0] redirect_tgt;
  logic            accept, drop, push, pop;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};

  // Credit uses registered occupancy only, so the FIFO can never overflow.
  always_comb begin
    level     = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req  = run_q && !redirect_valid && (level < LIMIT);
    imem_addr = pc_q;
    accept    = imem_req && imem_ready;
    drop      = imem_rvalid && (redirect_valid || (discard_q != '0));
    push      = imem_rvalid && !drop;
    pop       = if_valid && if_ready;

    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_tgt;
    else if (accept)     pc_d = pc_q + PC_STEP;

    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);

    discard_d = discard_q;
    if (redirect_valid)
      discard_d = outstanding_q - CW'(imem_rvalid);
    else if (imem_rvalid && (discard_q != '0))
      discard_d = discard_q - CW'(1);

    // Surviving responses are contiguous from the last redirect target.
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) rsp_pc_d = redirect_tgt;
    else if (push)      rsp_pc_d = rsp_pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      run_q         <= 1'b1;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_ni   (rst),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (redirect_valid),
    .wpc_i    (rsp_pc_q),
    .winstr_i (imem_rdata),
    .valid_o  (if_valid),
    .rpc_o    (if_pc),
    .rinstr_o (if_instr),
    .count_o  (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a 1- or 2-cycle memory model
// that returns the request address as the instruction word.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          mem_lat = 1;
  logic        p_v = 1'b0;
  logic [31:0] p_a = '0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q [$];

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, scoreboard, then drive memory after posedge.
  task automatic tick();
    logic        acc, pop_s, redir_s;
    logic [31:0] a, ppc, pin, e;
    @(negedge clk);
    acc     = imem_req && imem_ready;
    a       = imem_addr;
    pop_s   = if_valid && if_ready;
    redir_s = redirect_valid;
    ppc     = if_pc;
    pin     = if_instr;
    if (redir_s) begin
      chk("req_in_redirect", {31'b0, imem_req}, 32'd0);
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop_s) begin
        n_pop++;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", ppc, e);
          chk("sb_instr", pin, e);
        end
      end
      if (acc) begin
        chk("req_addr", a, exp_pc);
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (mem_lat == 2) begin
      imem_rvalid = p_v;
      imem_rdata  = p_a;
      p_v = acc;
      p_a = a;
    end else begin
      imem_rvalid = acc;
      imem_rdata  = a;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    while (!if_valid && i < max) begin
      tick();
      i++;
    end
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
    chk("redir_req_low", {31'b0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    exp_pc         = 32'h0;

    // Reset state without any clock edge yet.
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("start_req", {31'b0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, 32'h0);

    // Latency and sustained throughput with a 1-cycle memory.
    tick();
    chk("lat_n1_valid", {31'b0, if_valid}, 32'd0);
    chk("lat_n1_addr", imem_addr, 32'h4);
    tick();
    chk("lat_n2_valid", {31'b0, if_valid}, 32'd1);
    chk("lat_n2_pc", if_pc, 32'h0);
    chk("lat_n2_instr", if_instr, 32'h0);
    n_pop = 0;
    ticks(8);
    chk("throughput", 32'(n_pop), 32'd8);

    // Decode backpressure: requests stop once the buffer credit is used.
    if_ready = 1'b0;
    ticks(10);
    chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    if_ready = 1'b1;
    ticks(8);

    // Redirect coinciding with rvalid and pop at 1-cycle latency.
    redirect(32'h100);
    chk("r100_valid_low", {31'b0, if_valid}, 32'd0);
    chk("r100_addr", imem_addr, 32'h100);
    chk("r100_req", {31'b0, imem_req}, 32'd1);
    wait_valid("r100", 6);
    chk("r100_first_pc", if_pc, 32'h100);
    ticks(4);

    // Memory not ready: request and address hold at 0x8.
    redirect(32'h0);
    ticks(2);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      tick();
    end
    chk("stall_addr_end", imem_addr, 32'h8);
    imem_ready = 1'b1;
    mem_lat    = 2;
    ticks(8);

    // Redirect to an unaligned target with two fetches in flight.
    redirect(32'h43);
    chk("r43_valid_low", {31'b0, if_valid}, 32'd0);
    chk("r43_addr", imem_addr, 32'h40);
    chk("r43_req", {31'b0, imem_req}, 32'd1);
    wait_valid("r43", 8);
    chk("r43_first_pc", if_pc, 32'h40);
    ticks(4);

    // Back-to-back redirects: the later one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", imem_addr, 32'h300);
    wait_valid("b2b", 8);
    chk("b2b_first_pc", if_pc, 32'h300);
    ticks(4);

    imem_ready = 1'b0;
    ticks(3);
    mem_lat    = 1;
    imem_ready = 1'b1;
    ticks(6);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    imem_rvalid = 1'b0;
    p_v         = 1'b0;
    exp_q.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun_req", {31'b0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0);
    wait_valid("rerun", 6);
    chk("rerun_first_pc", if_pc, 32'h0);
    ticks(6);

    // Drain and confirm nothing expected was lost.
    imem_ready = 1'b0;
    ticks(6);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", {31'b0, if_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
